seq_detector_param: RTL and testbench

Parametrised serial sequence detector: matches a runtime-loadable N-bit pattern on a single-bit input stream. It generalises the fixed 11001 Mealy detector. It adds selectable overlapping/non-overlapping matching, a qualifying valid strobe, both Mealy (same-cycle) and registered (next-cycle) match outputs, and a saturating match counter. It sits on serial data paths as a framing/sync-word detector.

---
 rtl/seq_detector_param.sv | 67 ++++++
 tb/tb_seq_detector_param.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - runtime-loadable N-bit serial pattern detector with match counter
module seq_detector_param #(
  parameter int             N       = 5,
  parameter logic [N-1:0]   PAT_RST = 5'b11001,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [N-1:0]     pat_in,
  input  logic             clr_count,
  output logic             y,
  output logic             y_reg,
  output logic [CNT_W-1:0] match_count
);

  localparam int            FW        = $clog2(N + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(N);
  localparam logic [FW-1:0] FILL_ARM  = FW'(N - 1);

  logic [N-1:0]  pat;
  logic [N-1:0]  hist;
  logic [N-1:0]  cand;
  logic [FW-1:0] fill;
  logic          accept;

  assign cand   = {hist[N-2:0], din};
  assign accept = din_valid & ~pat_load;
  // fill gates out stale history left over from reset, reload or a non-overlap match
  assign y      = ~rst & accept & (fill >= FILL_ARM) & (cand == pat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat  <= PAT_RST;
      hist <= '0;
      fill <= '0;
    end else if (pat_load) begin
      pat  <= pat_in;
      fill <= '0;
    end else if (din_valid) begin
      hist <= cand;
      if (y && !overlap) begin
        fill <= '0;
      end else if (fill != FILL_FULL) begin
        fill <= fill + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_reg       <= 1'b0;
      match_count <= '0;
    end else begin
      y_reg <= y;
      if (clr_count) begin
        match_count <= '0;
      end else if (y && !(&match_count)) begin
        match_count <= match_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed self-checking bench for seq_detector_param
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       overlap;
  logic       pat_load;
  logic [4:0] pat_in;
  logic [1:0] pat_in2;
  logic       clr_count;

  logic       ya, yra, yb, yrb, yc, yrc;
  logic [7:0] cnta, cntc;
  logic [1:0] cntb;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_detector_param #(.N(5), .PAT_RST(5'b11001), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .clr_count(clr_count),
    .y(ya), .y_reg(yra), .match_count(cnta)
  );

  seq_detector_param #(.N(5), .PAT_RST(5'b11001), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .clr_count(clr_count),
    .y(yb), .y_reg(yrb), .match_count(cntb)
  );

  seq_detector_param #(.N(2), .PAT_RST(2'b11), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in2), .clr_count(clr_count),
    .y(yc), .y_reg(yrc), .match_count(cntc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] y_of(input int w);
    return (w == 0) ? 32'(ya) : (w == 1) ? 32'(yb) : 32'(yc);
  endfunction

  function automatic logic [31:0] yr_of(input int w);
    return (w == 0) ? 32'(yra) : (w == 1) ? 32'(yrb) : 32'(yrc);
  endfunction

  // drive one bit, check Mealy y mid-cycle, then y_reg just after the edge
  task automatic bit_in(input int w, input logic d, input logic v, input logic ey, input string tag);
    din       = d;
    din_valid = v;
    #2;
    chk({tag, ".y"}, y_of(w), 32'(ey));
    @(posedge clk);
    #1;
    chk({tag, ".y_reg"}, yr_of(w), 32'(ey));
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    pat_load  = 1'b0;
    clr_count = 1'b0;
    rst       = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  bit s1   [16] = '{0,1,1,0,0,1,1,0,0,1,0,1,1,0,0,1};
  bit e_ov [16] = '{0,0,0,0,0,1,0,0,0,1,0,0,0,0,0,1};
  bit e_no [16] = '{0,0,0,0,0,1,0,0,0,0,0,0,0,0,0,1};
  bit g_d  [9]  = '{0,1,0,1,1,0,1,1,1};
  bit g_v  [9]  = '{1,0,1,0,1,0,1,0,1};
  bit g_e  [9]  = '{0,0,0,0,0,0,0,0,1};
  bit p5   [5]  = '{1,1,0,0,1};
  bit p5b  [5]  = '{1,0,1,0,1};
  bit c_ov [4]  = '{0,1,1,1};
  bit c_no [4]  = '{0,1,0,1};

  initial begin
    rst       = 1'b1;
    din       = 1'b0;
    din_valid = 1'b1;
    overlap   = 1'b1;
    pat_load  = 1'b0;
    pat_in    = 5'b0;
    pat_in2   = 2'b0;
    clr_count = 1'b0;
    din       = 1'b1;
    #1;
    chk("rst.y", 32'(ya), 32'd0);
    chk("rst.y_reg", 32'(yra), 32'd0);
    chk("rst.cnt", 32'(cnta), 32'd0);
    @(posedge clk);
    #1;
    do_reset();

    overlap = 1'b1;
    for (int i = 0; i < 16; i++) bit_in(0, s1[i], 1'b1, e_ov[i], $sformatf("ov%0d", i + 1));
    chk("ov.cnt", 32'(cnta), 32'd3);

    do_reset();
    overlap = 1'b0;
    for (int i = 0; i < 16; i++) bit_in(0, s1[i], 1'b1, e_no[i], $sformatf("nov%0d", i + 1));
    chk("nov.cnt", 32'(cnta), 32'd2);

    // reload with a would-be match of the old pattern in the load cycle
    do_reset();
    overlap = 1'b1;
    for (int i = 0; i < 4; i++) bit_in(0, p5[i], 1'b1, 1'b0, $sformatf("pre%0d", i));
    din       = 1'b1;
    din_valid = 1'b1;
    pat_load  = 1'b1;
    pat_in    = 5'b00111;
    #2;
    chk("load.y", 32'(ya), 32'd0);
    @(posedge clk);
    #1;
    pat_load = 1'b0;
    chk("load.y_reg", 32'(yra), 32'd0);
    chk("load.cnt", 32'(cnta), 32'd0);
    for (int i = 0; i < 9; i++) bit_in(0, g_d[i], g_v[i], g_e[i], $sformatf("gap%0d", i));
    chk("gap.cnt", 32'(cnta), 32'd1);

    do_reset();
    overlap = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      for (int i = 0; i < 5; i++) bit_in(1, p5[i], 1'b1, (i == 4), $sformatf("sat%0d_%0d", k, i));
      chk($sformatf("sat.cnt%0d", k), 32'(cntb), (k < 3) ? 32'(k) : 32'd3);
    end
    for (int i = 0; i < 4; i++) bit_in(1, p5[i], 1'b1, 1'b0, $sformatf("clr%0d", i));
    clr_count = 1'b1;
    bit_in(1, 1'b1, 1'b1, 1'b1, "clr4");
    clr_count = 1'b0;
    chk("clr.cnt", 32'(cntb), 32'd0);

    // async reset must also revert a reloaded pattern
    do_reset();
    overlap  = 1'b1;
    pat_in   = 5'b10101;
    pat_load = 1'b1;
    @(posedge clk);
    #1;
    pat_load = 1'b0;
    for (int i = 0; i < 5; i++) bit_in(0, p5b[i], 1'b1, (i == 4), $sformatf("alt%0d", i));
    chk("alt.cnt", 32'(cnta), 32'd1);
    for (int i = 0; i < 4; i++) bit_in(0, p5[i], 1'b1, 1'b0, $sformatf("mid%0d", i));
    din       = 1'b1;
    din_valid = 1'b0;
    rst       = 1'b1;
    #1;
    chk("arst.y", 32'(ya), 32'd0);
    chk("arst.y_reg", 32'(yra), 32'd0);
    chk("arst.cnt", 32'(cnta), 32'd0);
    #2;
    rst = 1'b0;
    bit_in(0, 1'b1, 1'b1, 1'b0, "arst.b0");
    for (int i = 0; i < 5; i++) bit_in(0, p5[i], 1'b1, (i == 4), $sformatf("arst%0d", i));
    chk("arst.cnt1", 32'(cnta), 32'd1);

    do_reset();
    overlap = 1'b1;
    for (int i = 0; i < 4; i++) bit_in(2, 1'b1, 1'b1, c_ov[i], $sformatf("n2ov%0d", i + 1));
    chk("n2ov.cnt", 32'(cntc), 32'd3);
    do_reset();
    overlap = 1'b0;
    for (int i = 0; i < 4; i++) bit_in(2, 1'b1, 1'b1, c_no[i], $sformatf("n2nov%0d", i + 1));
    chk("n2nov.cnt", 32'(cntc), 32'd2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
